// File: rtl/load_align_wb_pkg.sv
// Shared load-return definitions: load select encodings
// and the byte-merge helper used by the lane aligner.
package load_align_wb_pkg;

  localparam logic [2:0] LD_SEL_LB   = 3'd0;
  localparam logic [2:0] LD_SEL_LH   = 3'd1;
  localparam logic [2:0] LD_SEL_LWL  = 3'd2;
  localparam logic [2:0] LD_SEL_LW   = 3'd3;
  localparam logic [2:0] LD_SEL_LBU  = 3'd4;
  localparam logic [2:0] LD_SEL_LHU  = 3'd5;
  localparam logic [2:0] LD_SEL_LWR  = 3'd6;
  localparam logic [2:0] LD_SEL_RSVD = 3'd7;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] al,
    input logic [31:0] old,
    input logic [3:0]  en
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = en[i] ? al[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/load_align_wb_lane_align.sv
// Combinational big-endian lane aligner: extracts, extends
// and merges the returned word and yields GPR byte enables.
module load_lane_align
  import load_align_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  sel,
  input  logic [31:0] rt_old,
  output logic [31:0] data,
  output logic [3:0]  byte_en
);

  logic [31:0] lwl_al;
  logic [31:0] lwr_al;
  logic [3:0]  lwl_en;
  logic [3:0]  lwr_en;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Shifted views; offset 0 is the most significant lane
  always_comb begin
    lwl_al = rdata << {addr, 3'b000};
    lwr_al = rdata >> {~addr, 3'b000};
    lwl_en = 4'b1111 << addr;
    lwr_en = 4'b1111 >> ~addr;
    byte_v = lwr_al[7:0];
    half_v = addr[1] ? rdata[15:0] : rdata[31:16];
  end

  // Per-select extension and merge
  always_comb begin
    data    = rt_old;
    byte_en = 4'b0000;
    unique case (sel)
      LD_SEL_LB: begin
        data    = {{24{byte_v[7]}}, byte_v};
        byte_en = 4'b1111;
      end
      LD_SEL_LBU: begin
        data    = {24'd0, byte_v};
        byte_en = 4'b1111;
      end
      LD_SEL_LH: begin
        data    = {{16{half_v[15]}}, half_v};
        byte_en = 4'b1111;
      end
      LD_SEL_LHU: begin
        data    = {16'd0, half_v};
        byte_en = 4'b1111;
      end
      LD_SEL_LW: begin
        data    = rdata;
        byte_en = 4'b1111;
      end
      LD_SEL_LWL: begin
        data    = merge_bytes(lwl_al, rt_old, lwl_en);
        byte_en = lwl_en;
      end
      LD_SEL_LWR: begin
        data    = merge_bytes(lwr_al, rt_old, lwr_en);
        byte_en = lwr_en;
      end
      default: begin
        data    = rt_old;
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_align_wb.sv
// MEM->WB load-return stage: captures a load, waits for memory,
// registers the aligned result and hands it to WB.
module load_align_wb
  import load_align_wb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_addr,
  input  logic [2:0]        req_load_sel,
  input  logic [31:0]       req_rt_old,
  input  logic [REG_AW-1:0] req_dest,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [3:0]        wb_byte_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic              load_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        addr_q, addr_d;
  logic [2:0]        sel_q, sel_d;
  logic [31:0]       rt_q, rt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        en_q, en_d;
  logic [31:0]       al_data;
  logic [3:0]        al_en;
  logic              capture;

  load_lane_align u_align (
    .rdata   (mem_rdata),
    .addr    (addr_q),
    .sel     (sel_q),
    .rt_old  (rt_q),
    .data    (al_data),
    .byte_en (al_en)
  );

  // Next-state, capture and handshake decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    en_d      = en_q;
    req_ready = 1'b0;
    load_err  = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          capture = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          data_d  = al_data;
          en_d    = al_en;
          state_d = S_HOLD;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          load_err = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_HOLD: begin
        req_ready = wb_ready && !flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (wb_ready) begin
          if (req_valid) begin
            capture = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (!flush && mem_rvalid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture)
      cnt_d = 8'd0;
  end

  // Request capture registers next values
  always_comb begin
    addr_d = capture ? req_addr     : addr_q;
    sel_d  = capture ? req_load_sel : sel_q;
    rt_d   = capture ? req_rt_old   : rt_q;
    dest_d = capture ? req_dest     : dest_q;
  end

  // State, counter, capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      rt_q    <= '0;
      dest_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      rt_q    <= rt_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  // Writeback presentation
  always_comb begin
    wb_valid   = (state_q == S_HOLD);
    wb_data    = data_q;
    wb_byte_en = en_q;
    wb_dest    = dest_q;
  end

endmodule

// File: tb/tb_load_align_wb.sv
// Directed self-checking bench for load_align_wb.
// Timeout shortened to 4 cycles.
module tb_load_align_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [2:0]  req_load_sel;
  logic [31:0] req_rt_old;
  logic [4:0]  req_dest;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_byte_en;
  logic [4:0]  wb_dest;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_align_wb #(.TIMEOUT(4), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_load_sel (req_load_sel),
    .req_rt_old   (req_rt_old),
    .req_dest     (req_dest),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_byte_en   (wb_byte_en),
    .wb_dest      (wb_dest),
    .load_err     (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 2'd0;
    req_load_sel = 3'd0;
    req_rt_old   = 32'd0;
    req_dest     = 5'd0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'd0;
    wb_ready     = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] sel, input logic [1:0] a,
                           input logic [31:0] rt, input logic [4:0] d);
    req_valid    = 1'b1;
    req_load_sel = sel;
    req_addr     = a;
    req_rt_old   = rt;
    req_dest     = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl rdy=%b vld=%b err=%b exp 1 0 0",
               req_ready, wb_valid, load_err);
    end
    checks++;
    if (wb_data !== 32'd0 || wb_byte_en !== 4'd0 || wb_dest !== 5'd0) begin
      errors++;
      $display("FAIL reset_data data=%h en=%b dest=%0d exp 0",
               wb_data, wb_byte_en, wb_dest);
    end
  endtask

  task automatic test_lb_latency();
    drive_req(3'd0, 2'd1, 32'h0, 5'd7);
    settle();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_accept req_ready=%b exp 1", req_ready);
    end
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12F45678;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL lb_wait vld=%b rdy=%b exp 0 0", wb_valid, req_ready);
    end
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFFF4 ||
        wb_byte_en !== 4'b1111 || wb_dest !== 5'd7) begin
      errors++;
      $display("FAIL lb_result vld=%b data=%h en=%b dest=%0d exp 1 fffffff4 1111 7",
               wb_valid, wb_data, wb_byte_en, wb_dest);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_release vld=%b rdy=%b exp 0 1", wb_valid, req_ready);
    end
  endtask

  task automatic test_align();
    logic [2:0]  sel_t [12] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd1, 3'd5,
                                3'd3, 3'd2, 3'd6, 3'd2, 3'd6, 3'd7};
    logic [1:0]  adr_t [12] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1,
                                2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1};
    logic [31:0] rd_t  [12] = '{32'h80F17F02, 32'h80F17F02, 32'h80F17F02,
                                32'h80F17F02, 32'h80F17F02, 32'h80F17F02,
                                32'h80F17F02, 32'h80F17F02, 32'h80F17F02,
                                32'h80F17F02, 32'h80F17F02, 32'h80F17F02};
    logic [31:0] exp_d [12] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                32'hFFFF80F1, 32'h00007F02, 32'h000080F1,
                                32'h80F17F02, 32'h80F17F02, 32'h80F17F02,
                                32'h02223344, 32'h11223380, 32'h11223344};
    logic [3:0]  exp_e [12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'hF, 4'hF, 4'hF, 4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      drive_req(sel_t[i], adr_t[i], 32'h11223344, 5'(i + 1));
      tick();
      req_valid  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rd_t[i];
      tick();
      mem_rvalid = 1'b0;
      settle();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp_d[i] ||
          wb_byte_en !== exp_e[i] || wb_dest !== 5'(i + 1)) begin
        errors++;
        $display("FAIL align_%0d vld=%b data=%h en=%b dest=%0d exp 1 %h %b %0d",
                 i, wb_valid, wb_data, wb_byte_en, wb_dest,
                 exp_d[i], exp_e[i], i + 1);
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
    end
  endtask

  task automatic test_lwl_lwr();
    drive_req(3'd2, 2'd2, 32'h11223344, 5'd3);
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAABBCCDD;
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_data !== 32'hCCDD3344 || wb_byte_en !== 4'b1100) begin
      errors++;
      $display("FAIL lwl data=%h en=%b exp ccdd3344 1100", wb_data, wb_byte_en);
    end
    wb_ready = 1'b1;
    drive_req(3'd6, 2'd1, 32'h11223344, 5'd4);
    tick();
    wb_ready   = 1'b0;
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAABBCCDD;
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1122AABB || wb_byte_en !== 4'b0011) begin
      errors++;
      $display("FAIL lwr vld=%b data=%h en=%b exp 1 1122aabb 0011",
               wb_valid, wb_data, wb_byte_en);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_req(3'd5, 2'd2, 32'h0, 5'd9);
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234ABCD;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0000ABCD || wb_dest !== 5'd9 ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d vld=%b data=%h dest=%0d rdy=%b exp 1 0000abcd 9 0",
                 i, wb_valid, wb_data, wb_dest, req_ready);
      end
      tick();
    end
    wb_ready = 1'b1;
    drive_req(3'd3, 2'd0, 32'h0, 5'd10);
    settle();
    checks++;
    if (req_ready !== 1'b1 || wb_data !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL b2b_accept rdy=%b data=%h exp 1 0000abcd", req_ready, wb_data);
    end
    tick();
    wb_ready   = 1'b0;
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    settle();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait vld=%b exp 0", wb_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_dest !== 5'd10) begin
      errors++;
      $display("FAIL b2b_result vld=%b data=%h dest=%0d exp 1 cafef00d 10",
               wb_valid, wb_data, wb_dest);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive_req(3'd3, 2'd0, 32'h0, 5'd5);
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    settle();
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
      end
      settle();
      checks++;
      if (req_ready !== 1'b0 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d rdy=%b vld=%b exp 0 0", i, req_ready, wb_valid);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit rdy=%b vld=%b exp 1 0", req_ready, wb_valid);
    end
    drive_req(3'd3, 2'd0, 32'h0, 5'd6);
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0BADF00D || wb_dest !== 5'd6) begin
      errors++;
      $display("FAIL post_flush vld=%b data=%h dest=%0d exp 1 0badf00d 6",
               wb_valid, wb_data, wb_dest);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_flush vld=%b rdy=%b exp 0 1", wb_valid, req_ready);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    drive_req(3'd3, 2'd0, 32'h0, 5'd2);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      checks++;
      if (load_err !== (c == 4)) begin
        errors++;
        $display("FAIL timeout_c%0d load_err=%b exp %b", c, load_err, c == 4);
      end
      if (load_err === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulses count=%0d exp 1", pulses);
    end
    settle();
    checks++;
    if (req_ready !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drain rdy=%b vld=%b exp 0 0", req_ready, wb_valid);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_exit rdy=%b vld=%b err=%b exp 1 0 0",
               req_ready, wb_valid, load_err);
    end
  endtask

  task automatic test_rst_mid();
    drive_req(3'd3, 2'd0, 32'h0, 5'd12);
    tick();
    req_valid  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77778888;
    tick();
    mem_rvalid = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1 || wb_data !== 32'd0 ||
        wb_byte_en !== 4'd0 || wb_dest !== 5'd0) begin
      errors++;
      $display("FAIL rst_hold vld=%b rdy=%b data=%h en=%b dest=%0d exp 0 1 0 0 0",
               wb_valid, req_ready, wb_data, wb_byte_en, wb_dest);
    end
    drive_req(3'd3, 2'd0, 32'h0, 5'd13);
    tick();
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99990000;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1 || wb_dest !== 5'd0) begin
      errors++;
      $display("FAIL rst_wait vld=%b rdy=%b dest=%0d exp 0 1 0",
               wb_valid, req_ready, wb_dest);
    end
    tick();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_rvalid vld=%b rdy=%b exp 0 1", wb_valid, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lb_latency();
    test_align();
    test_lwl_lwr();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
